// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer.
// Optional counters are enabled by defining COMMIT_TRACE_COUNTERS_EN.
package commit_trace_buffer_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [ILEN-1:0] TRAP_INSTR = 32'h0005006b;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            wen;
        logic [RW-1:0]   wdest;
        logic [XLEN-1:0] wdata;
    } commit_rec_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/commit_trace_buffer.sv
// Multi-lane commit trace FIFO with trap detection and halt.
// Define COMMIT_TRACE_COUNTERS_EN to build the cycle/instruction counters.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      in_valid,
    input  logic [NPORTS*64-1:0]   in_pc,
    input  logic [NPORTS*32-1:0]   in_instr,
    input  logic [NPORTS-1:0]      in_wen,
    input  logic [NPORTS*5-1:0]    in_wdest,
    input  logic [NPORTS*64-1:0]   in_wdata,
    output logic                   in_ready,
    input  logic [63:0]            a0,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic                   out_wen,
    output logic [4:0]             out_wdest,
    output logic [63:0]            out_wdata,
    output logic                   trap_valid,
    output logic [7:0]             trap_code,
    output logic [63:0]            trap_pc,
    output logic [63:0]            cycle_cnt,
    output logic [63:0]            instr_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    commit_rec_t       mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    state_t            state;

    logic              accept;
    logic              deq;
    logic [CW-1:0]     n_enq;
    logic [PW-1:0]     slot [NPORTS];
    commit_rec_t       lane_rec [NPORTS];
    commit_rec_t       head_rec;
    logic              unused_a0;

    assign unused_a0 = ^a0[63:8];

    // Prefix count of valid lanes gives each lane its slot offset from tail.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            slot[i]           = tail + PW'(n_enq);
            lane_rec[i].pc    = in_pc[i*64 +: 64];
            lane_rec[i].instr = in_instr[i*32 +: 32];
            lane_rec[i].wen   = in_wen[i] && (in_wdest[i*5 +: 5] != 5'd0);
            lane_rec[i].wdest = in_wdest[i*5 +: 5];
            lane_rec[i].wdata = in_wdata[i*64 +: 64];
            if (in_valid[i]) begin
                n_enq = n_enq + CW'(1);
            end
        end
    end

    // Handshakes depend only on start-of-cycle state, never on a same-cycle dequeue.
    assign in_ready  = reset && (state == RUN) && ((CW'(DEPTH) - count) >= CW'(NPORTS));
    assign out_valid = reset && (state == RUN) && (count != '0);
    assign accept    = in_ready;
    assign deq       = out_valid && out_ready;

    assign head_rec  = mem[head];
    assign out_pc    = head_rec.pc;
    assign out_instr = head_rec.instr;
    assign out_wen   = head_rec.wen;
    assign out_wdest = head_rec.wdest;
    assign out_wdata = head_rec.wdata;

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(NPORTS); i++) begin
                if (in_valid[i]) begin
                    mem[slot[i]] <= lane_rec[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= RUN;
            trap_valid <= 1'b0;
            trap_code  <= 8'd0;
            trap_pc    <= 64'd0;
        end else begin
            trap_valid <= 1'b0;
            if (accept) begin
                tail <= tail + PW'(n_enq);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + (accept ? n_enq : CW'(0)) - (deq ? CW'(1) : CW'(0));
            if (deq && (head_rec.instr == TRAP_INSTR)) begin
                state      <= HALTED;
                trap_valid <= 1'b1;
                trap_pc    <= head_rec.pc;
                trap_code  <= a0[7:0];
            end
        end
    end

`ifdef COMMIT_TRACE_COUNTERS_EN
    // Counters run only while RUN; HALTED freezes them until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= 64'd0;
            instr_cnt <= 64'd0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (deq) begin
                instr_cnt <= instr_cnt + 64'd1;
            end
        end
    end
`else
    assign cycle_cnt = 64'd0;
    assign instr_cnt = 64'd0;
`endif

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of commit lanes accepted per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, a power of two, at least 2*NPORTS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port in_valid, input, NPORTS bits: per-lane commit valid.
REQ-006 SHALL have ports in_pc, in_instr, in_wen, in_wdest and in_wdata, all inputs, NPORTS x 64, 32, 1, 5 and 64 bits: per-lane commit record.
REQ-007 SHALL have port in_ready, output, 1 bit: the buffer can accept a full NPORTS-lane group this cycle.
REQ-008 SHALL have port a0, input, 64 bits: architectural x10, used as the trap code.
REQ-009 SHALL have ports out_valid and out_ready: output 1 bit and input 1 bit, the drain handshake.
REQ-010 SHALL have ports out_pc, out_instr, out_wen, out_wdest and out_wdata, all outputs, 64, 32, 1, 5 and 64 bits: the head record.
REQ-011 SHALL have ports trap_valid (1 bit), trap_code (8 bits) and trap_pc (64 bits), all outputs.
REQ-012 SHALL have ports cycle_cnt and instr_cnt, both outputs, 64 bits each.

Function
REQ-013 SHALL be a circular FIFO with head and tail pointers modulo DEPTH and a registered occupancy count of $clog2(DEPTH)+1 bits.
REQ-014 SHALL drive in_ready=1 iff state==RUN and DEPTH-count>=NPORTS, using the start-of-cycle count; a same-cycle dequeue SHALL NOT raise in_ready.
REQ-015 SHALL, on a cycle with in_ready=1, write the valid lanes in ascending lane order into consecutive slots, skip invalid lanes, and advance tail by popcount(in_valid).
REQ-016 SHALL ignore in_valid entirely when in_ready=0; the producer holds its lanes.
REQ-017 SHALL force the stored wen to 0 when in_wdest==0.
REQ-018 SHALL drive out_valid=1 iff count>0 and state==RUN; the head record is presented with no bypass, so minimum enqueue-to-out_valid latency is 1 cycle.
REQ-019 SHALL dequeue on out_valid && out_ready; a simultaneous enqueue and dequeue SHALL update count by enqueued minus dequeued.
REQ-020 SHALL have states RUN and HALTED; RUN goes to HALTED when a dequeued record has instr==TRAP_INSTR (32'h0005006b).
REQ-021 SHALL, on that dequeue, pulse trap_valid for 1 cycle on the next cycle, with trap_pc=out_pc and trap_code=a0[7:0] sampled at the dequeue edge.
REQ-022 SHALL, in HALTED, hold out_valid=0 and in_ready=0 and freeze the contents and counters until reset.
REQ-023 SHALL increment instr_cnt by 1 per dequeue, the trap record included.
REQ-024 SHALL increment cycle_cnt by 1 every cycle in RUN; both counters wrap at 2^64.

Reset
REQ-025 SHALL, with reset=0 at a clock edge, set head=tail=count=0, state=RUN, trap_valid=0, trap_code=0, trap_pc=0, cycle_cnt=0 and instr_cnt=0, mid-operation included; buffered entries are discarded.
REQ-026 SHALL, while reset=0, drive in_ready=0 and out_valid=0; data outputs are don't-care while out_valid=0.

Configuration
REQ-027 SHALL, with COMMIT_TRACE_COUNTERS_EN defined, implement cycle_cnt and instr_cnt as specified.
REQ-028 SHALL, with COMMIT_TRACE_COUNTERS_EN undefined, tie cycle_cnt and instr_cnt to 0 and implement no counter flops; all other behaviour is unchanged.

Structure
REQ-029 SHALL place the commit record struct (pc, instr, wen, wdest, wdata) and the TRAP_INSTR constant in the shared common package.
REQ-030 SHALL be a single module with no sub-module; lane compaction is an in-module prefix-count.

Verification
REQ-031 SHALL cover dual-lane enqueue: NPORTS=2, in_valid=2'b11, pcs 0x80000000/0x80000004, out_ready=1 -> the two drain in order on consecutive cycles and instr_cnt=2.
REQ-032 SHALL cover sparse lanes: in_valid=2'b10, pc 0x80000010 -> one entry stored, tail+1, out_pc=0x80000010 the next cycle.
REQ-033 SHALL cover full: DEPTH=8, out_ready=0, four 2-lane groups -> in_ready=0 after count=8; one dequeue gives count=7 and in_ready stays 0.
REQ-034 SHALL cover x0 write: in_wdest=0, in_wen=1 -> out_wen=0.
REQ-035 SHALL cover trap: drain instr 0x0005006b at pc 0x80000100 with a0=0 -> trap_valid pulses once with trap_code=0 and trap_pc=0x80000100, then out_valid=0 permanently.
REQ-036 SHALL cover reset mid-run: reset=0 with count=5 -> count=0, cycle_cnt=0 and out_valid=0 on the next cycle.
